// File: rtl/pipelined_barrel_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready handshakes on both sides.
// Stage 1 applies the low half of the shift-amount bits. Stage 2 applies the
// rest, forces the all-fill result when the amount overflows, and registers Op/err.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] Ip,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] Op,
  output logic             err
);
  localparam int LG = $clog2(WIDTH);
  localparam int L1 = (LG + 1) / 2;   // amount bits resolved in stage 1
  localparam int L2 = LG - L1;        // amount bits resolved in stage 2

  // One mux level: shift by k toward the MSB (d=0) or the LSB (d=1).
  // Vacated bits are filled with the fill bit, or with wrapped bits when rotating.
  // Bit WIDTH-1 of the packed vector corresponds to Ip[0].
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input int k,
                                            input logic d, input logic rot, input logic fill);
    logic [WIDTH-1:0] ones, r;
    ones = '1;
    if (!d) begin
      r = v << k;
      if (rot)       r = r | (v >> (WIDTH - k));
      else if (fill) r = r | ~(ones << k);
    end else begin
      r = v >> k;
      if (rot)       r = r | (v << (WIDTH - k));
      else if (fill) r = r | ~(ones >> k);
    end
    return r;
  endfunction

  // Stage 1 payload
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [L2-1:0]    s1_hi;
  logic             s1_ovf, s1_fill, s1_dir, s1_rot, s1_err;
  // Stage 2 holds valid only; its payload lives directly in Op/err
  logic             s2_valid;

  logic             s2_adv, accept;
  logic             rot_in, fill_in, ovf_in;
  logic [WIDTH-1:0] s1_sh, s2_sh;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  // Decode the operation. Reserved mode behaves like logical.
  // Rotate takes the amount mod WIDTH, so it never overflows.
  assign rot_in  = (mode == 2'b10);
  assign fill_in = (mode == 2'b01) && dir && Ip[0];
  assign ovf_in  = !rot_in && (32'(shift_amt) >= WIDTH);

  // Stage-1 shifter: low amount bits
  always_comb begin
    s1_sh = Ip;
    for (int j = 0; j < L1; j++)
      if (shift_amt[j]) s1_sh = step(s1_sh, 1 << j, dir, rot_in, fill_in);
  end

  // Stage-2 shifter: remaining amount bits; an overflowed amount yields pure fill
  always_comb begin
    s2_sh = s1_data;
    for (int j = 0; j < L2; j++)
      if (s1_hi[j]) s2_sh = step(s2_sh, 1 << (j + L1), s1_dir, s1_rot, s1_fill);
    if (s1_ovf) s2_sh = {WIDTH{s1_fill}};
  end

  // Stage 1 register: load on accept, drain when it moves into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_hi    <= '0;
      s1_ovf   <= 1'b0;
      s1_fill  <= 1'b0;
      s1_dir   <= 1'b0;
      s1_rot   <= 1'b0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= s1_sh;
      s1_hi    <= shift_amt[LG-1:L1];
      s1_ovf   <= ovf_in;
      s1_fill  <= fill_in;
      s1_dir   <= dir;
      s1_rot   <= rot_in;
      s1_err   <= (mode == 2'b11);
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: advances only when empty or being consumed; otherwise Op holds
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      Op       <= '0;
      err      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        Op  <= s2_sh;
        err <= s1_err;
      end
    end
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (WIDTH=8). It runs directed vectors, a stall
// scenario, reset mid-flight and a randomized stream. All results are compared
// against an arithmetic reference model.
module tb_pipelined_barrel_shifter;
  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, dir, out_valid, out_ready, err;
  logic [0:W-1]  Ip, Op;
  logic [AW-1:0] shift_amt;
  logic [1:0]    mode;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [7:0] op; logic err; } res_t;
  res_t q[$];

  pipelined_barrel_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .Ip(Ip),
    .shift_amt(shift_amt), .dir(dir), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .Op(Op), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: plain shift/rotate arithmetic on an 8-bit value (bit 7 = Ip[0])
  function automatic res_t model(input logic [7:0] x, input int amt, input logic d, input logic [1:0] m);
    res_t r;
    int a;
    r.err = (m == 2'b11);
    if (m == 2'b10) begin
      a = amt % W;
      if (!d) r.op = (x << a) | (x >> (W - a));
      else    r.op = (x >> a) | (x << (W - a));
    end else if (amt >= W) begin
      r.op = (m == 2'b01 && d) ? {8{x[7]}} : 8'h00;
    end else if (!d) begin
      r.op = x << amt;
    end else if (m == 2'b01) begin
      r.op = $signed(x) >>> amt;
    end else begin
      r.op = x >> amt;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest accepted operation
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          assert (q.size() != 0) else begin
            failures++;
            $error("FAIL sb_extra got=%0h exp=none", Op);
          end
        end else begin
          res_t e, g;
          e = q.pop_front();
          g.op = Op; g.err = err;
          assert (g === e) else begin
            failures++;
            $error("FAIL sb_result got=%0h/%0b exp=%0h/%0b", g.op, g.err, e.op, e.err);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(Ip, int'(shift_amt), dir, mode));
    end
  end

  // Single operation on an idle pipe: present, check latency, check the result
  task automatic dop(input string tag, input logic [7:0] ip, input int amt, input logic d,
                     input logic [1:0] m, input logic [7:0] eop, input logic eerr);
    in_valid = 1'b1; Ip = ip; shift_amt = AW'(amt); dir = d; mode = m;
    @(negedge clk); chk({tag, "_rdy"}, 32'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk({tag, "_early"}, 32'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_vld"}, 32'(out_valid), 1);
    chk({tag, "_op"}, 32'(Op), 32'(eop));
    chk({tag, "_err"}, 32'(err), 32'(eerr));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held;
    logic       accepted;
    int         acc, cyc;
    logic [7:0] sops [6];

    // Reset with in_valid asserted: inputs must be ignored
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; Ip = 8'hFF; shift_amt = '0; dir = 1'b0; mode = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_op", 32'(Op), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors
    dop("lsl2",   8'hAD, 2,  1'b0, 2'b00, 8'hB4, 1'b0);
    dop("lsr2",   8'hAD, 2,  1'b1, 2'b00, 8'h2B, 1'b0);
    dop("asr2",   8'hAD, 2,  1'b1, 2'b01, 8'hEB, 1'b0);
    dop("asr9",   8'hAD, 9,  1'b1, 2'b01, 8'hFF, 1'b0);
    dop("lsr9",   8'hAD, 9,  1'b1, 2'b00, 8'h00, 1'b0);
    dop("rol3",   8'hAD, 3,  1'b0, 2'b10, 8'h6D, 1'b0);
    dop("ror1",   8'hAD, 1,  1'b1, 2'b10, 8'hD6, 1'b0);
    dop("rol11",  8'hAD, 11, 1'b0, 2'b10, 8'h6D, 1'b0);
    dop("rsv",    8'h01, 1,  1'b0, 2'b11, 8'h02, 1'b1);
    dop("after",  8'h01, 1,  1'b0, 2'b00, 8'h02, 1'b0);
    dop("zero_l", 8'hAD, 0,  1'b0, 2'b00, 8'hAD, 1'b0);
    dop("zero_a", 8'hAD, 0,  1'b1, 2'b01, 8'hAD, 1'b0);
    dop("zero_r", 8'hAD, 0,  1'b1, 2'b10, 8'hAD, 1'b0);
    dop("asr_pos",8'h2D, 2,  1'b1, 2'b01, 8'h0B, 1'b0);
    dop("asl8",   8'hAD, 8,  1'b0, 2'b01, 8'h00, 1'b0);
    dop("rot8",   8'hAD, 8,  1'b0, 2'b10, 8'hAD, 1'b0);

    // Stream of 6 with out_ready low for cycles 2..4
    for (int i = 0; i < 6; i++) sops[i] = 8'($urandom);
    acc = 0; cyc = 0; held = '0;
    while (acc < 6 && cyc < 50) begin
      in_valid = 1'b1; Ip = sops[acc]; shift_amt = AW'(acc + 1); dir = acc[0]; mode = 2'(acc % 3);
      out_ready = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      if (cyc == 2) begin
        chk("stall_in_ready", 32'(in_ready), 0);
        chk("stall_accepts", 32'(acc), 2);
        held = Op;
      end
      if (cyc == 3 || cyc == 4) begin
        chk("stall_hold_op", 32'(Op), 32'(held));
        chk("stall_out_valid", 32'(out_valid), 1);
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) acc++;
      cyc++;
    end
    chk("stream_accepts", 32'(acc), 6);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin @(posedge clk); #1; end
    chk("stream_drain", 32'(q.size()), 0);

    // Accept two operations, then reset mid-flight
    in_valid = 1'b1; Ip = 8'h5A; shift_amt = 4'd1; dir = 1'b0; mode = 2'b00;
    @(posedge clk); #1 Ip = 8'hC3;
    @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_mid_out_valid", 32'(out_valid), 0);
      chk("rst_mid_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    dop("post_rst", 8'h81, 1, 1'b1, 2'b01, 8'hC0, 1'b0);

    // Randomized stream with random backpressure; the producer holds until accepted
    accepted = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom % 4) != 0;
        Ip = 8'($urandom); shift_amt = AW'($urandom); dir = 1'($urandom); mode = 2'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin @(posedge clk); #1; end
    chk("rand_drain", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits; legal values are powers of two, 4..64.
REQ-002 Parameter AMT_W, default $clog2(WIDTH)+1: shift-amount width, which allows amounts up to and above WIDTH.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  an operation is presented on Ip/shift_amt/dir/mode.
REQ-006 in_ready  output  1  the block can accept an operation this cycle.
REQ-007 Ip  input  WIDTH  operand; declared [0:WIDTH-1], so index 0 is the MSB.
REQ-008 shift_amt  input  AMT_W  unsigned shift distance.
REQ-009 dir  input  1  0 = left (toward index 0), 1 = right (toward index WIDTH-1).
REQ-010 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-011 out_valid  output  1  Op/err hold a completed result.
REQ-012 out_ready  input  1  the consumer accepts the result this cycle.
REQ-013 Op  output  WIDTH  result; declared [0:WIDTH-1].
REQ-014 err  output  1  the result came from a reserved-mode operation.

Function
REQ-015 The block is a two-stage pipeline: S1 and S2, each holding one valid bit plus its payload.
REQ-016 An input transfer occurs on any cycle where in_valid && in_ready.
REQ-017 An output transfer occurs on any cycle where out_valid && out_ready.
REQ-018 S1 captures Ip, dir, mode and the fill bit, and applies the low ceil(log2(WIDTH)/2) bits of the effective amount.
REQ-019 S2 applies the remaining amount bits and drives Op, out_valid and err directly from flops.
REQ-020 Latency: with no stall, a result is valid on Op exactly 2 cycles after its input transfer.
REQ-021 Throughput is one operation per cycle while out_ready=1.
REQ-022 in_ready = !S1.valid || S2 can advance, where S2 can advance = !S2.valid || out_ready.
REQ-023 in_ready depends combinationally only on state and out_ready, never on in_valid.
REQ-024 S1 moves into S2 only when S2 can advance.
REQ-025 When S2 cannot advance, S1 and S2 hold their contents and Op stays stable; no result is dropped or duplicated.
REQ-026 Results leave in the same order operations were accepted.
REQ-027 Logical mode: vacated bit positions fill with 0.
REQ-028 Arithmetic mode with dir=1: vacated positions fill with Ip[0].
REQ-029 Arithmetic mode with dir=0: identical to logical left.
REQ-030 Rotate mode: bits leaving one end re-enter at the other; the effective amount is shift_amt mod WIDTH.
REQ-031 Logical or arithmetic with shift_amt >= WIDTH: the result is all fill bits (0, or Ip[0] for arithmetic right).
REQ-032 shift_amt = 0 in any mode: Op equals Ip.
REQ-033 mode=11: the operation is executed as logical and its result carries err=1.
REQ-034 err is 0 for every other mode and travels through the pipeline with its result.
REQ-035 When in_valid=1 and in_ready=0, the producer holds its inputs; the block samples nothing.
REQ-036 On a cycle with a simultaneous input transfer and output transfer while both stages are full, both transfers complete and the pipeline stays full.

Reset
REQ-037 While rst=1 at a clock edge, S1.valid and S2.valid clear to 0.
REQ-038 After reset: out_valid=0, err=0, Op=0, and in_ready=1 in the first cycle after rst deasserts.
REQ-039 Reset asserted mid-operation discards every in-flight result; no out_valid pulse follows reset.
REQ-040 Inputs are ignored in any cycle where rst=1.

Verification (WIDTH=8, out_ready=1 unless stated otherwise)
REQ-041 Ip=1010_1101, dir=0, mode=00, amt=2 -> Op=1011_0100 two cycles later; then dir=1 -> Op=0010_1011.
REQ-042 Ip=1010_1101, dir=1, mode=01, amt=2 -> Op=1110_1011; then amt=9 -> Op=1111_1111; then mode=00, amt=9 -> Op=0000_0000.
REQ-043 Ip=1010_1101, mode=10: dir=0, amt=3 -> 0110_1101; dir=1, amt=1 -> 1101_0110; dir=0, amt=11 -> 0110_1101.
REQ-044 Back-to-back stream of 6 operations with out_ready held at 0 for 3 cycles mid-stream -> in_ready drops after 2 accepts, Op is held stable during the stall, and all 6 results arrive in order with no loss.
REQ-045 mode=11, Ip=0000_0001, dir=0, amt=1 -> Op=0000_0010 with err=1; the next mode=00 result has err=0.
REQ-046 Accept 2 operations, then assert rst for 1 cycle -> out_valid stays 0 afterward, in_ready=1, and the next operation is processed normally.
